// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO for the execute stage.
// Magnitude shift-add multiply / restoring divide, sign fix-up applied once at the end.
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        ihit,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [32:0]   acc_reg;     // product upper half / partial remainder
  logic [31:0]   q_reg;       // multiplier (shifting out) / quotient (shifting in)
  logic [31:0]   m_reg;       // multiplicand / divisor magnitude
  logic          sgn_reg, div_reg, neg_a_reg, neg_b_reg, dz_reg;
  logic [31:0]   hi_reg, lo_reg;

  logic          accept, last_iter;
  logic [31:0]   mag_rs, mag_rt;
  logic [32:0]   mul_sum;
  logic [32:0]   div_shift;
  logic [33:0]   div_diff;
  logic          div_ok;
  logic [63:0]   prod, prod_neg;
  logic [31:0]   quo_neg, rem_neg;
  logic [31:0]   fix_hi, fix_lo;

  assign accept    = start & ihit & ~flush;
  assign last_iter = (cnt_reg == CW'(ITER - 1));
  assign mag_rs    = (op[0] & rs[31]) ? -rs : rs;
  assign mag_rt    = (op[0] & rt[31]) ? -rt : rt;

  assign mul_sum   = acc_reg + (q_reg[0] ? {1'b0, m_reg} : 33'd0);
  assign div_shift = {acc_reg[31:0], q_reg[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, m_reg};
  assign div_ok    = ~div_diff[33];

  assign prod      = {acc_reg[31:0], q_reg};
  assign prod_neg  = -prod;
  assign quo_neg   = -q_reg;
  assign rem_neg   = -acc_reg[31:0];

  // Divide by zero always yields all-ones quotient; remainder fix-up restores rs exactly.
  always_comb begin
    fix_hi = 32'd0;
    fix_lo = 32'd0;
    if (div_reg) begin
      fix_hi = (sgn_reg & neg_a_reg) ? rem_neg : acc_reg[31:0];
      if (dz_reg)
        fix_lo = 32'hFFFF_FFFF;
      else
        fix_lo = (sgn_reg & (neg_a_reg ^ neg_b_reg)) ? quo_neg : q_reg;
    end else if (sgn_reg & (neg_a_reg ^ neg_b_reg)) begin
      {fix_hi, fix_lo} = prod_neg;
    end else begin
      {fix_hi, fix_lo} = prod;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Stall drops in DONE so a following MFHI/MFLO sees the committed values.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          stall      = 1'b1;
          state_next = op[1] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (flush)          state_next = IDLE;
        else if (last_iter) state_next = FIX;
      end
      FIX: begin
        stall      = 1'b1;
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      sgn_reg   <= 1'b0;
      div_reg   <= 1'b0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      dz_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            q_reg     <= op[1] ? mag_rs : mag_rt;
            m_reg     <= op[1] ? mag_rt : mag_rs;
            sgn_reg   <= op[0];
            div_reg   <= op[1];
            neg_a_reg <= rs[31];
            neg_b_reg <= rt[31];
            dz_reg    <= (rt == 32'd0);
          end
        end
        MUL: begin
          acc_reg <= {1'b0, mul_sum[32:1]};
          q_reg   <= {mul_sum[0], q_reg[31:1]};
          cnt_reg <= cnt_reg + CW'(1);
        end
        DIV: begin
          acc_reg <= div_ok ? div_diff[32:0] : div_shift;
          q_reg   <= {q_reg[30:0], div_ok};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          if (!flush) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule
